// File: rtl/sev_seg_scan_driver.sv
// Multi-digit seven-segment driver: serial double-dabble binary-to-BCD, sign and
// leading-zero handling, and a time-multiplexed scan onto one shared segment bus.
module sev_seg_scan_driver #(
   parameter int DATA_W      = 8,
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 50000,
   parameter int ACT_HIGH    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] value,
   input  logic              is_neg,
   input  logic              blank_lz,
   output logic              busy,
   output logic              overflow,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dig_en
);

   localparam int BCD_N  = DATA_W / 3 + 1;
   localparam int SCR_W  = 4 * BCD_N;
   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W  = $clog2(DIGITS);
   localparam int STEP_W = $clog2(DATA_W);

   localparam logic [6:0] SEG_MINUS = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   val_q, val_d;
   logic                neg_q, neg_d;
   logic [SCR_W-1:0]    bcd_q, bcd_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [6:0]          disp_q [DIGITS];
   logic [6:0]          disp_d [DIGITS];
   logic                ovf_q, ovf_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          nib [DIGITS];
   int                  sig_n;
   logic [6:0]          seg_raw;
   logic [DIGITS-1:0]   dig_raw;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0: seg_code = 7'b0111111;
         4'd1: seg_code = 7'b0000110;
         4'd2: seg_code = 7'b1011011;
         4'd3: seg_code = 7'b1001111;
         4'd4: seg_code = 7'b1100110;
         4'd5: seg_code = 7'b1101101;
         4'd6: seg_code = 7'b1111101;
         4'd7: seg_code = 7'b0000111;
         4'd8: seg_code = 7'b1111111;
         4'd9: seg_code = 7'b1100111;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

   // One double-dabble step: +3 on every nibble >= 5, then shift in the next bit.
   function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] b, input logic bit_in);
      logic [SCR_W-1:0] adj;
      for (int i = 0; i < BCD_N; i++)
         adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
      dabble_step = {adj[SCR_W-2:0], bit_in};
   endfunction

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      neg_d   = neg_q;
      bcd_d   = bcd_q;
      step_d  = step_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               val_d   = value;
               neg_d   = is_neg;
               bcd_d   = '0;
               step_d  = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            bcd_d  = dabble_step(bcd_q, val_q[DATA_W-1]);
            val_d  = {val_q[DATA_W-2:0], 1'b0};
            step_d = step_q + 1'b1;
            if (step_q == STEP_W'(DATA_W - 1))
               state_d = COMMIT;
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_nib
         if (gi < BCD_N) begin : g_in
            assign nib[gi] = bcd_q[4*gi +: 4];
         end else begin : g_pad
            assign nib[gi] = 4'd0;
         end
         assign dig_raw[gi] = (idx_q == IDX_W'(gi));
      end
   endgenerate

   // Significant digit count over the whole scratch; zero still counts as one digit.
   always_comb begin
      sig_n = 1;
      for (int i = 0; i < BCD_N; i++)
         if (bcd_q[4*i +: 4] != 4'd0)
            sig_n = i + 1;
   end

   always_comb begin
      disp_d = disp_q;
      ovf_d  = ovf_q;
      if (state_q == COMMIT) begin
         ovf_d = (sig_n > DIGITS) || (neg_q && sig_n >= DIGITS);
         for (int i = 0; i < DIGITS; i++) begin
            if (ovf_d)
               disp_d[i] = SEG_MINUS;
            else if (neg_q && (blank_lz ? (i == sig_n) : (i == DIGITS - 1)))
               disp_d[i] = SEG_MINUS;
            else if (!blank_lz || i < sig_n)
               disp_d[i] = seg_code(nib[i]);
            else
               disp_d[i] = SEG_BLANK;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         val_q   <= '0;
         neg_q   <= 1'b0;
         bcd_q   <= '0;
         step_q  <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         for (int i = 0; i < DIGITS; i++)
            disp_q[i] <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         neg_q   <= neg_d;
         bcd_q   <= bcd_d;
         step_q  <= step_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         for (int i = 0; i < DIGITS; i++)
            disp_q[i] <= disp_d[i];
      end
   end

   // Segment data and enable both come straight from registers, so they switch together.
   always_comb begin
      seg_raw = SEG_BLANK;
      for (int i = 0; i < DIGITS; i++)
         if (idx_q == IDX_W'(i))
            seg_raw = disp_q[i];
   end

   assign overflow = ovf_q;

   generate
      if (ACT_HIGH != 0) begin : g_pos
         assign seg    = seg_raw;
         assign dig_en = dig_raw;
      end else begin : g_neg
         assign seg    = ~seg_raw;
         assign dig_en = ~dig_raw;
      end
   endgenerate

endmodule

// File: doc/sev_seg_scan_driver.md
Name: sev_seg_scan_driver

Overview:
- Parametrised multi-digit seven-segment display driver for the calculator result path.
- Accepts an unsigned binary magnitude plus a sign flag.
- Converts the magnitude to BCD sequentially using shift-add-3 (double dabble), one bit per clock.
- Applies leading-zero blanking and minus-sign placement, then time-multiplexes the digits onto one shared segment bus with one-hot digit enables.

Parameters:
- DATA_W, 8, width of the binary magnitude input (>=4).
- DIGITS, 3, number of physical display digits (>=2).
- REFRESH_DIV, 50000, clock cycles each digit stays enabled (>=2).
- ACT_HIGH, 1, 1 = seg/dig_en active-high; 0 = both bit-inverted at the output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  request to convert and display value/is_neg.
- value  input  DATA_W  unsigned magnitude.
- is_neg  input  1  show a minus sign.
- blank_lz  input  1  1 = blank leading zeros.
- busy  output  1  conversion in progress; load is ignored while high.
- overflow  output  1  last committed result did not fit in DIGITS.
- seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a.
- dig_en  output  DIGITS  one-hot digit enable; bit0 = least-significant digit.

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - FSM = IDLE, busy=0, overflow=0.
  - All display registers = BLANK.
  - Refresh counter = 0, scan index = 0.
  - dig_en = one-hot bit0 (polarity per ACT_HIGH); seg = blank (all segments off).
- Reset mid-conversion aborts the conversion; the display stays blank.
- FSM states: IDLE -> CONV -> COMMIT -> IDLE.
- IDLE:
  - load=1 at a rising edge captures value and is_neg, clears the BCD scratch, and enters CONV.
  - blank_lz is sampled in COMMIT, not at load.
- CONV:
  - Exactly DATA_W cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts left one bit, taking the next value bit MSB first.
  - Scratch width is 4*(DATA_W/3+1) bits, so nothing is truncated internally.
- COMMIT (1 cycle) writes all display registers and overflow atomically, then returns to IDLE.
- Timing: load sampled at edge k -> busy=1 after edge k through edge k+DATA_W+1 -> new display and overflow visible after edge k+DATA_W+1. Total DATA_W+1 busy cycles.
- load while busy is ignored; no queueing.
- Back-to-back: load held high re-triggers on the first IDLE cycle.
- Commit rules, where n = number of significant BCD digits (value 0 gives n=1):
  - n > DIGITS -> overflow=1; every digit shows MINUS.
  - blank_lz=1: digits >= n are BLANK. If is_neg, digit n shows MINUS; if n == DIGITS, overflow instead.
  - blank_lz=0: leading zeros are shown. If is_neg, the top digit shows MINUS; this requires n <= DIGITS-1, otherwise overflow.
  - Otherwise overflow=0.
- Segment codes:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111
  - MINUS=1000000, BLANK=0000000
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - When the counter wraps, the scan index advances, wrapping from DIGITS-1 to 0.
  - dig_en is the one-hot of the index. seg is the code of the display register at that index and changes in the same cycle as dig_en; no cross-digit glitch cycle.
  - A commit does not reset the scan.
- ACT_HIGH=0 inverts seg and dig_en, including the reset values.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> seg=0000000, dig_en=001, busy=0, overflow=0 without waiting for a clock edge.
- Load at defaults:
  - value=0, blank_lz=1 -> busy for exactly 9 cycles; digits (2,1,0) = BLANK, BLANK, 0111111.
  - value=255 -> 1001111 (2), 1101101 (5), 1101101 (5); overflow=0.
- Sign placement:
  - value=42, is_neg=1, blank_lz=1 -> MINUS, 1100110 (4), 1011011 (2).
  - value=7, is_neg=1, blank_lz=0 -> MINUS, 0111111 (0), 0000111 (7).
- Overflow:
  - value=255, is_neg=1, DIGITS=3 -> overflow=1, all digits MINUS.
  - A following load of value=5 -> overflow=0 after commit.
- Handshake: load value=12, then pulse load with value=99 three cycles later -> second load ignored; display shows 12. A load one cycle after busy falls is accepted.
- Scan with REFRESH_DIV=4, DIGITS=3:
  - dig_en sequence 001,010,100,001, each held 4 cycles.
  - seg matches the enabled digit every cycle.
  - ACT_HIGH=0 build -> both outputs bit-inverted.
  - Reset asserted during CONV -> display blank and busy=0 after reset release.
